clock_control: RTL

Run/halt/single-step controller that sits directly upstream of the gated `Clock` generator and drives its `i_enable`. It runs on the free-running board clock and turns operator commands (run, halt, step) and the CPU halt signal into a clean, cycle-exact enable. It also counts enabled cycles for debug readout.

---
 rtl/clock_control_pkg.sv | 25 ++
 rtl/clock_control_edge_detect.sv | 25 ++
 rtl/clock_control.sv | 108 ++++++++++
 3 files changed

// File: rtl/clock_control_pkg.sv
// Shared types and constants for the run/halt/single-step clock controller.
package clock_control_pkg;

  typedef enum logic [1:0] {
    ST_HALTED   = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_STEPPING = 2'd2,
    ST_STOPPED  = 2'd3
  } state_e;

  localparam int STEP_CYCLES_MIN = 1;
  localparam int STEP_CYCLES_MAX = 255;

  // Out-of-range step lengths are clamped so the 8-bit step counter never loads 0 or overflows.
  function automatic logic [7:0] clamp_step(input int value);
    if (value < STEP_CYCLES_MIN) begin
      return 8'(STEP_CYCLES_MIN);
    end else if (value > STEP_CYCLES_MAX) begin
      return 8'(STEP_CYCLES_MAX);
    end else begin
      return 8'(value);
    end
  endfunction

endpackage

// File: rtl/clock_control_edge_detect.sv
// Single-bit rising-edge detector; a level already high when reset is released never fires.
module edge_detect (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_in,
  output logic o_rise
);

  logic r_prev;
  logic r_armed;

  // Armed only after the first edge out of reset, so a held level must fall and rise again.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_prev  <= i_in;
      r_armed <= 1'b1;
    end
  end

  assign o_rise = i_in & ~r_prev & r_armed;

endmodule

// File: rtl/clock_control.sv
// Run/halt/single-step controller producing a glitch-free enable for the gated clock,
// plus a saturating count of enabled cycles.
module clock_control
  import clock_control_pkg::*;
#(
  parameter int STEP_CYCLES = 1,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_run,
  input  logic                   i_halt,
  input  logic                   i_step,
  input  logic                   i_hlt,
  output logic                   o_enable,
  output logic [1:0]             o_state,
  output logic                   o_step_done,
  output logic [COUNT_WIDTH-1:0] o_cycles
);

  localparam logic [7:0]             STEP_LOAD = clamp_step(STEP_CYCLES);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = {COUNT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  logic                   w_run_rise;
  logic                   w_halt_rise;
  logic                   w_step_rise;
  logic                   w_enable;
  state_e                 r_state;
  logic [7:0]             r_step_cnt;
  logic                   r_step_done;
  logic [COUNT_WIDTH-1:0] r_cycles;

  edge_detect u_run_edge  (.i_clock(i_clock), .i_reset(i_reset), .i_in(i_run),  .o_rise(w_run_rise));
  edge_detect u_halt_edge (.i_clock(i_clock), .i_reset(i_reset), .i_in(i_halt), .o_rise(w_halt_rise));
  edge_detect u_step_edge (.i_clock(i_clock), .i_reset(i_reset), .i_in(i_step), .o_rise(w_step_rise));

  // Command FSM: priority is CPU HLT, then halt, then step, then run.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_HALTED;
      r_step_cnt  <= 8'd0;
      r_step_done <= 1'b0;
    end else begin
      r_step_done <= 1'b0;
      case (r_state)
        ST_HALTED: begin
          if (w_halt_rise) begin
            r_state <= ST_HALTED;
          end else if (w_step_rise) begin
            r_state    <= ST_STEPPING;
            r_step_cnt <= STEP_LOAD;
          end else if (w_run_rise) begin
            r_state <= ST_RUNNING;
          end
        end
        ST_RUNNING: begin
          if (i_hlt) begin
            r_state <= ST_STOPPED;
          end else if (w_halt_rise) begin
            r_state <= ST_HALTED;
          end
        end
        ST_STEPPING: begin
          if (i_hlt) begin
            r_state    <= ST_STOPPED;
            r_step_cnt <= 8'd0;
          end else if (w_halt_rise) begin
            r_state    <= ST_HALTED;
            r_step_cnt <= 8'd0;
          end else if (r_step_cnt <= 8'd1) begin
            r_state     <= ST_HALTED;
            r_step_cnt  <= 8'd0;
            r_step_done <= 1'b1;
          end else begin
            r_step_cnt <= r_step_cnt - 8'd1;
          end
        end
        ST_STOPPED: begin
          if (w_halt_rise) begin
            r_state <= ST_HALTED;
          end
        end
        default: begin
          r_state    <= ST_HALTED;
          r_step_cnt <= 8'd0;
        end
      endcase
    end
  end

  assign w_enable = (r_state == ST_RUNNING) || (r_state == ST_STEPPING);

  // Enabled-cycle counter, sticks at all-ones.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cycles <= {COUNT_WIDTH{1'b0}};
    end else if (w_enable && (r_cycles != CNT_MAX)) begin
      r_cycles <= r_cycles + CNT_ONE;
    end
  end

  assign o_enable    = w_enable;
  assign o_state     = r_state;
  assign o_step_done = r_step_done;
  assign o_cycles    = r_cycles;

endmodule
